// File: rtl/control_sequencer_if.sv
// Control bundle between the fetch/decode/execute sequencer and the ALU
// system datapath: instruction and flag inputs plus every datapath control pin.
interface control_sequencer_if;
    logic        Run;
    logic [15:0] IROut;
    logic [3:0]  ALUFlags;

    logic [2:0]  RF_OutASel;
    logic [2:0]  RF_OutBSel;
    logic [2:0]  RF_FunSel;
    logic [3:0]  RF_RegSel;
    logic [3:0]  RF_ScrSel;
    logic [4:0]  ALU_FunSel;
    logic        ALU_WF;
    logic [1:0]  ARF_OutCSel;
    logic [1:0]  ARF_OutDSel;
    logic [2:0]  ARF_FunSel;
    logic [2:0]  ARF_RegSel;
    logic        IR_LH;
    logic        IR_Write;
    logic        Mem_CS;
    logic        Mem_WR;
    logic [1:0]  MuxASel;
    logic [1:0]  MuxBSel;
    logic        MuxCSel;
    logic        Halted;
    logic        Illegal;

    // Sequencer side: consumes instruction/flags, drives the controls
    modport master (
        input  Run, IROut, ALUFlags,
        output RF_OutASel, RF_OutBSel, RF_FunSel, RF_RegSel, RF_ScrSel,
               ALU_FunSel, ALU_WF, ARF_OutCSel, ARF_OutDSel, ARF_FunSel,
               ARF_RegSel, IR_LH, IR_Write, Mem_CS, Mem_WR,
               MuxASel, MuxBSel, MuxCSel, Halted, Illegal
    );

    // Datapath side: supplies instruction/flags, receives the controls
    modport slave (
        output Run, IROut, ALUFlags,
        input  RF_OutASel, RF_OutBSel, RF_FunSel, RF_RegSel, RF_ScrSel,
               ALU_FunSel, ALU_WF, ARF_OutCSel, ARF_OutDSel, ARF_FunSel,
               ARF_RegSel, IR_LH, IR_Write, Mem_CS, Mem_WR,
               MuxASel, MuxBSel, MuxCSel, Halted, Illegal
    );
endinterface

// File: rtl/control_sequencer.sv
// Hardwired fetch/decode/execute controller. Fetches a 16-bit instruction as
// two byte reads (low byte first) into IR, then drives the datapath controls
// for a single execute cycle. Outputs are combinational from state and IROut.
module control_sequencer (
    input  logic                        Clock,
    input  logic                        Reset,
    control_sequencer_if.master         bus
);
    localparam logic [2:0] FUN_DEC   = 3'b000;
    localparam logic [2:0] FUN_INC   = 3'b001;
    localparam logic [2:0] FUN_LOAD  = 3'b010;
    localparam logic [2:0] FUN_CLR   = 3'b011;
    localparam logic [4:0] ALU_PASSB = 5'b10001;

    localparam logic [2:0] S_INIT    = 3'd0;
    localparam logic [2:0] S_FETCH_L = 3'd1;
    localparam logic [2:0] S_FETCH_H = 3'd2;
    localparam logic [2:0] S_EXEC    = 3'd3;
    localparam logic [2:0] S_HALT    = 3'd4;

    logic [2:0] state_reg;
    logic [2:0] state_next;

    // Instruction fields
    logic [3:0] op;
    logic [1:0] rx;
    logic [1:0] rs;
    logic [3:0] rx_onehot;

    assign op = bus.IROut[15:12];
    assign rx = bus.IROut[11:10];
    assign rs = bus.IROut[9:8];

    // Rx = 00 selects R1 (bit 3) down to Rx = 11 selecting R4 (bit 0)
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_rx_dec
            assign rx_onehot[3-gi] = (rx == gi[1:0]);
        end
    endgenerate

    // State register; reset forces INIT without waiting for a clock edge
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state_reg <= S_INIT;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_INIT:    state_next = S_FETCH_L;
            S_FETCH_L: state_next = bus.Run ? S_FETCH_H : S_FETCH_L;
            S_FETCH_H: state_next = S_EXEC;
            S_EXEC:    state_next = (op == 4'hF) ? S_HALT : S_FETCH_L;
            S_HALT:    state_next = S_HALT;
            default:   state_next = S_INIT;
        endcase
    end

    // Control decode; everything defaults to idle. While Reset is held low the
    // outputs stay idle so an interrupted fetch or store is abandoned at once
    // and the INIT clear only appears after release.
    always_comb begin
        bus.RF_OutASel  = 3'b000;
        bus.RF_OutBSel  = 3'b000;
        bus.RF_FunSel   = 3'b000;
        bus.RF_RegSel   = 4'b0000;
        bus.RF_ScrSel   = 4'b0000;
        bus.ALU_FunSel  = 5'b00000;
        bus.ALU_WF      = 1'b0;
        bus.ARF_OutCSel = 2'b00;
        bus.ARF_OutDSel = 2'b00;
        bus.ARF_FunSel  = 3'b000;
        bus.ARF_RegSel  = 3'b000;
        bus.IR_LH       = 1'b0;
        bus.IR_Write    = 1'b0;
        bus.Mem_CS      = 1'b1;
        bus.Mem_WR      = 1'b0;
        bus.MuxASel     = 2'b00;
        bus.MuxBSel     = 2'b00;
        bus.MuxCSel     = 1'b0;
        bus.Halted      = 1'b0;
        bus.Illegal     = 1'b0;

        if (Reset) begin
            case (state_reg)
                S_INIT: begin
                    bus.ARF_FunSel = FUN_CLR;
                    bus.ARF_RegSel = 3'b111;
                    bus.RF_FunSel  = FUN_CLR;
                    bus.RF_RegSel  = 4'b1111;
                    bus.RF_ScrSel  = 4'b1111;
                end
                S_FETCH_L, S_FETCH_H: begin
                    // Read Memory[PC] into one IR byte and bump PC
                    if (bus.Run || state_reg == S_FETCH_H) begin
                        bus.ARF_OutCSel = 2'b00;
                        bus.Mem_CS      = 1'b0;
                        bus.IR_Write    = 1'b1;
                        bus.IR_LH       = (state_reg == S_FETCH_H);
                        bus.ARF_FunSel  = FUN_INC;
                        bus.ARF_RegSel  = 3'b100;
                    end
                end
                S_EXEC: begin
                    case (op)
                        4'h0: ;
                        4'h1: begin
                            bus.MuxASel   = 2'b10;
                            bus.RF_FunSel = FUN_LOAD;
                            bus.RF_RegSel = rx_onehot;
                        end
                        4'h2: begin
                            bus.ARF_OutCSel = 2'b10;
                            bus.Mem_CS      = 1'b0;
                            bus.MuxASel     = 2'b11;
                            bus.RF_FunSel   = FUN_LOAD;
                            bus.RF_RegSel   = rx_onehot;
                        end
                        4'h3: begin
                            bus.RF_OutBSel  = {1'b0, rx};
                            bus.MuxCSel     = 1'b1;
                            bus.ALU_FunSel  = ALU_PASSB;
                            bus.ARF_OutCSel = 2'b10;
                            bus.Mem_CS      = 1'b0;
                            bus.Mem_WR      = 1'b1;
                        end
                        4'h4: begin
                            bus.RF_OutBSel = {1'b0, rs};
                            bus.MuxCSel    = 1'b1;
                            bus.ALU_FunSel = ALU_PASSB;
                            bus.ALU_WF     = 1'b1;
                            bus.MuxASel    = 2'b00;
                            bus.RF_FunSel  = FUN_LOAD;
                            bus.RF_RegSel  = rx_onehot;
                        end
                        4'h5, 4'h6: begin
                            bus.RF_FunSel = (op == 4'h5) ? FUN_INC : FUN_DEC;
                            bus.RF_RegSel = rx_onehot;
                        end
                        4'h7: begin
                            bus.MuxBSel    = 2'b10;
                            bus.ARF_FunSel = FUN_LOAD;
                            bus.ARF_RegSel = 3'b010;
                        end
                        4'h8, 4'h9: begin
                            // BZ only branches when the registered Z flag is set
                            if (op == 4'h8 || bus.ALUFlags[3]) begin
                                bus.MuxBSel    = 2'b10;
                                bus.ARF_FunSel = FUN_LOAD;
                                bus.ARF_RegSel = 3'b100;
                            end
                        end
                        4'hF: ;
                        default: bus.Illegal = 1'b1;
                    endcase
                end
                S_HALT: bus.Halted = 1'b1;
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_control_sequencer.sv
// Bench for control_sequencer: directed decode table, hand-written reset/halt
// sequences, then random instructions against an instruction-level model.
module tb_control_sequencer;
    typedef struct packed {
        logic [2:0] oa;
        logic [2:0] ob;
        logic [2:0] rf_fun;
        logic [3:0] rf_reg;
        logic [3:0] rf_scr;
        logic [4:0] alu_fun;
        logic       alu_wf;
        logic [1:0] csel;
        logic [1:0] dsel;
        logic [2:0] arf_fun;
        logic [2:0] arf_reg;
        logic       ir_lh;
        logic       ir_wr;
        logic       cs;
        logic       wr;
        logic [1:0] ma;
        logic [1:0] mb;
        logic       mc;
        logic       halted;
        logic       illegal;
    } ctl_t;

    typedef struct {
        logic [15:0] ir;
        logic [3:0]  flags;
        ctl_t        exp;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int checks = 0;
    int failures = 0;

    control_sequencer_if bus ();

    control_sequencer dut (
        .Clock (clk),
        .Reset (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    ctl_t act;
    assign act = {bus.RF_OutASel, bus.RF_OutBSel, bus.RF_FunSel, bus.RF_RegSel,
                  bus.RF_ScrSel, bus.ALU_FunSel, bus.ALU_WF, bus.ARF_OutCSel,
                  bus.ARF_OutDSel, bus.ARF_FunSel, bus.ARF_RegSel, bus.IR_LH,
                  bus.IR_Write, bus.Mem_CS, bus.Mem_WR, bus.MuxASel, bus.MuxBSel,
                  bus.MuxCSel, bus.Halted, bus.Illegal};

    function automatic ctl_t idle_ref();
        ctl_t e = '0;
        e.cs = 1'b1;
        return e;
    endfunction

    function automatic ctl_t init_ref();
        ctl_t e = idle_ref();
        e.arf_fun = 3'b011; e.arf_reg = 3'b111;
        e.rf_fun = 3'b011; e.rf_reg = 4'b1111; e.rf_scr = 4'b1111;
        return e;
    endfunction

    function automatic ctl_t fetch_ref(input logic lh);
        ctl_t e = idle_ref();
        e.csel = 2'b00; e.cs = 1'b0; e.ir_wr = 1'b1; e.ir_lh = lh;
        e.arf_fun = 3'b001; e.arf_reg = 3'b100;
        return e;
    endfunction

    // Instruction semantics: which register file / address register is
    // written, from where, and whether memory or flags are touched.
    function automatic ctl_t exec_ref(input logic [15:0] ir, input logic [3:0] fl);
        ctl_t e = idle_ref();
        int op = int'(ir[15:12]);
        logic [3:0] dest = 4'b1000 >> ir[11:10];
        bit writes_rf = (op >= 1 && op <= 6 && op != 3);
        bit takes_branch = (op == 8) || (op == 9 && fl[3]);
        if (writes_rf) e.rf_reg = dest;
        if (op == 1 || op == 2 || op == 4) e.rf_fun = 3'b010;
        if (op == 5) e.rf_fun = 3'b001;
        if (op == 1) e.ma = 2'b10;
        if (op == 2) e.ma = 2'b11;
        if (op == 2 || op == 3) begin e.csel = 2'b10; e.cs = 1'b0; end
        if (op == 3) begin e.wr = 1'b1; e.ob = {1'b0, ir[11:10]}; end
        if (op == 4) begin e.ob = {1'b0, ir[9:8]}; e.alu_wf = 1'b1; end
        if (op == 3 || op == 4) begin e.mc = 1'b1; e.alu_fun = 5'b10001; end
        if (op == 7 || takes_branch) begin
            e.mb = 2'b10; e.arf_fun = 3'b010;
            e.arf_reg = (op == 7) ? 3'b010 : 3'b100;
        end
        if (op >= 10 && op <= 14) e.illegal = 1'b1;
        return e;
    endfunction

    task automatic check(input string name, input ctl_t exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s t=%0t got=%h want=%h", name, $time, act, exp);
        end
    endtask

    // Drive inputs, compare mid low-phase, advance to the next falling edge
    task automatic cyc(input string name, input logic run, input logic [15:0] ir,
                       input logic [3:0] fl, input ctl_t exp);
        bus.Run = run; bus.IROut = ir; bus.ALUFlags = fl;
        #1;
        check(name, exp);
        @(negedge clk);
    endtask

    vec_t vt[14];
    ctl_t e;
    ctl_t halt_e;

    initial begin
        bus.Run = 1'b0; bus.IROut = '0; bus.ALUFlags = '0;
        halt_e = idle_ref();
        halt_e.halted = 1'b1;

        // Decode table: instruction, flags, expected EXEC controls
        e = idle_ref(); e.ma = 2'b10; e.rf_fun = 3'b010; e.rf_reg = 4'b0100;
        vt[0] = '{16'h15A5, 4'h0, e};
        e = idle_ref(); e.ob = 3'b001; e.mc = 1'b1; e.alu_fun = 5'b10001; e.alu_wf = 1'b1;
        e.rf_fun = 3'b010; e.rf_reg = 4'b0001;
        vt[1] = '{16'h4D00, 4'h0, e};
        e = idle_ref(); e.mb = 2'b10; e.arf_fun = 3'b010; e.arf_reg = 3'b100;
        vt[2] = '{16'h903C, 4'b1000, e};
        vt[3] = '{16'h903C, 4'b0000, idle_ref()};
        vt[4] = '{16'h903C, 4'b0111, idle_ref()};
        e = idle_ref(); e.csel = 2'b10; e.cs = 1'b0; e.ma = 2'b11; e.rf_fun = 3'b010;
        e.rf_reg = 4'b0001;
        vt[5] = '{16'h2C00, 4'h0, e};
        e = idle_ref(); e.ob = 3'b010; e.mc = 1'b1; e.alu_fun = 5'b10001; e.csel = 2'b10;
        e.cs = 1'b0; e.wr = 1'b1;
        vt[6] = '{16'h3800, 4'hF, e};
        e = idle_ref(); e.rf_fun = 3'b001; e.rf_reg = 4'b1000;
        vt[7] = '{16'h5000, 4'h0, e};
        e = idle_ref(); e.rf_fun = 3'b000; e.rf_reg = 4'b0100;
        vt[8] = '{16'h6400, 4'h8, e};
        e = idle_ref(); e.mb = 2'b10; e.arf_fun = 3'b010; e.arf_reg = 3'b010;
        vt[9] = '{16'h7012, 4'h0, e};
        e = idle_ref(); e.mb = 2'b10; e.arf_fun = 3'b010; e.arf_reg = 3'b100;
        vt[10] = '{16'h80FF, 4'h0, e};
        vt[11] = '{16'h0123, 4'h8, idle_ref()};
        e = idle_ref(); e.illegal = 1'b1;
        vt[12] = '{16'hB000, 4'h0, e};
        vt[13] = '{16'hE555, 4'h8, e};

        // Reset held: outputs idle; release: one INIT cycle, then FETCH_L hold
        @(negedge clk);
        cyc("reset_idle", 1'b0, 16'h0, 4'h0, idle_ref());
        rst_n = 1'b1;
        cyc("init_clear", 1'b0, 16'h0, 4'h0, init_ref());
        for (int i = 0; i < 5; i++) cyc("fetch_hold", 1'b0, 16'h0, 4'h0, idle_ref());

        // Table: fetch low, fetch high (Run low, ignored), exec, then idle
        for (int i = 0; i < 14; i++) begin
            cyc("fetch_l", 1'b1, 16'h0, 4'h0, fetch_ref(1'b0));
            cyc("fetch_h", 1'b0, 16'h0, 4'h0, fetch_ref(1'b1));
            cyc($sformatf("exec_%h_%h", vt[i].ir, vt[i].flags), 1'b0, vt[i].ir,
                vt[i].flags, vt[i].exp);
            cyc("post_exec", 1'b0, vt[i].ir, 4'h0, idle_ref());
        end

        // HLT: idle exec then Halted held with Run toggling
        cyc("hlt_fetch_l", 1'b1, 16'h0, 4'h0, fetch_ref(1'b0));
        cyc("hlt_fetch_h", 1'b1, 16'h0, 4'h0, fetch_ref(1'b1));
        cyc("hlt_exec", 1'b1, 16'hF000, 4'h0, idle_ref());
        for (int i = 0; i < 10; i++)
            cyc("halted", logic'(i[0]), 16'h15A5, 4'h8, halt_e);

        // Reset exits HALT; then reset asserted mid FETCH_H
        rst_n = 1'b0;
        cyc("halt_reset", 1'b1, 16'h0, 4'h0, idle_ref());
        rst_n = 1'b1;
        cyc("init_again", 1'b1, 16'h0, 4'h0, init_ref());
        cyc("rf_fetch_l", 1'b1, 16'h0, 4'h0, fetch_ref(1'b0));
        bus.Run = 1'b1;
        #1;
        check("rf_fetch_h", fetch_ref(1'b1));
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset_idle", idle_ref());
        @(negedge clk);
        rst_n = 1'b1;
        cyc("init_after_abort", 1'b0, 16'h0, 4'h0, init_ref());
        cyc("hold_after_abort", 1'b0, 16'h0, 4'h0, idle_ref());

        // Random traffic against an instruction-level model
        begin
            int bytes_done = 0;
            bit halted = 0;
            bit init_pend = 0;
            for (int n = 0; n < 600; n++) begin
                logic run;
                logic [15:0] ir;
                logic [3:0] fl;
                ctl_t exp;
                if ($urandom_range(0, halted ? 7 : 49) == 0) begin
                    rst_n = 1'b0;
                    cyc("rnd_reset", 1'($urandom), 16'($urandom), 4'($urandom), idle_ref());
                    rst_n = 1'b1;
                    init_pend = 1; halted = 0; bytes_done = 0;
                    continue;
                end
                run = 1'($urandom);
                ir = 16'($urandom);
                fl = 4'($urandom);
                if (ir[15:12] == 4'hF && $urandom_range(0, 3) != 0) ir[15:12] = 4'h0;
                if (init_pend) begin
                    exp = init_ref(); init_pend = 0;
                end else if (halted) begin
                    exp = halt_e;
                end else if (bytes_done == 0) begin
                    exp = run ? fetch_ref(1'b0) : idle_ref();
                    if (run) bytes_done = 1;
                end else if (bytes_done == 1) begin
                    exp = fetch_ref(1'b1); bytes_done = 2;
                end else begin
                    exp = exec_ref(ir, fl); bytes_done = 0;
                    if (ir[15:12] == 4'hF) halted = 1;
                end
                cyc("rnd", run, ir, fl, exp);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/control_sequencer.md
Name: control_sequencer

Overview:
- Hardwired fetch/decode/execute controller for the ALU system datapath (RF, ARF, IR, ALU, Memory, MuxA/B/C).
- Fetches each 16-bit instruction as two byte reads from Memory at PC into IR, low byte first.
- Decodes IROut and drives every datapath control input for one execute cycle.
- Sits beside the datapath top. Its outputs connect one-to-one to the datapath control pins; its inputs are IROut and the registered ALU flags.

Parameters:
FUN_DEC, 3'b000, RF/ARF FunSel code for decrement
FUN_INC, 3'b001, RF/ARF FunSel code for increment
FUN_LOAD, 3'b010, RF/ARF FunSel code for load from I
FUN_CLR, 3'b011, RF/ARF FunSel code for clear
ALU_PASSB, 5'b10001, ALU_FunSel code with ALUOut = B and flags computed on B

Ports:
Clock  in  1  rising-edge clock
Reset  in  1  asynchronous active-low reset
Run  in  1  permits a new fetch when high
IROut  in  16  instruction register contents
ALUFlags  in  4  registered flags {Z,C,N,O}; Z is bit 3
RF_OutASel, RF_OutBSel  out  3 each  RF read selects
RF_FunSel  out  3  RF function
RF_RegSel, RF_ScrSel  out  4 each  one-hot RF write enables, bit3=R1 .. bit0=R4
ALU_FunSel  out  5  ALU function
ALU_WF  out  1  ALU flag write enable
ARF_OutCSel, ARF_OutDSel  out  2 each  00/01=PC, 10=AR, 11=SP
ARF_FunSel  out  3  ARF function
ARF_RegSel  out  3  one-hot ARF write enables, bit2=PC, bit1=AR, bit0=SP
IR_LH, IR_Write  out  1 each  IR byte select (0=low) and write enable
Mem_CS, Mem_WR  out  1 each  active-low chip select; WR 1=write
MuxASel, MuxBSel  out  2 each  00=ALUOut, 01=OutC, 10=IR[7:0], 11=MemOut
MuxCSel  out  1  0=ALUOut, 1=zero
Halted  out  1  high in HALT
Illegal  out  1  one-cycle pulse on an undefined opcode in EXEC

Behaviour:
- States: INIT, FETCH_L, FETCH_H, EXEC, HALT. Register is 3 bits.
- Reset low: the state goes to INIT asynchronously.
- Idle outputs:
  - All RegSel/ScrSel = 0, IR_Write = 0, Mem_CS = 1, Mem_WR = 0, ALU_WF = 0.
  - Every other select/function output = 0.
  - Halted = 0, Illegal = 0.
- Outputs are combinational from state and IROut. Any field not listed for a state holds its idle value.
- INIT (exactly one cycle after Reset releases):
  - ARF_FunSel = FUN_CLR, ARF_RegSel = 3'b111.
  - RF_FunSel = FUN_CLR, RF_RegSel = 4'b1111, RF_ScrSel = 4'b1111.
  - Next state: FETCH_L.
- FETCH_L:
  - If Run = 0: outputs idle, state holds.
  - If Run = 1: ARF_OutCSel = 00, Mem_CS = 0, IR_Write = 1, IR_LH = 0, ARF_FunSel = FUN_INC, ARF_RegSel = 3'b100. Next state: FETCH_H.
- FETCH_H: same as FETCH_L with Run = 1, but IR_LH = 1. Run is ignored. Next state: EXEC.
- EXEC:
  - Fields: op = IROut[15:12], Rx = IROut[11:10], Rs = IROut[9:8], imm = IROut[7:0].
  - RF one-hot for Rx: 00 gives 4'b1000 .. 11 gives 4'b0001.
  - RF read selects = {1'b0, Rx or Rs}.
  - Next state is FETCH_L, except HLT, which goes to HALT.
- EXEC opcodes:
  - 0 NOP: idle outputs.
  - 1 LDI: MuxASel = 10, RF_FunSel = FUN_LOAD, RF_RegSel = onehot(Rx).
  - 2 LD: ARF_OutCSel = 10, Mem_CS = 0, MuxASel = 11, RF_FunSel = FUN_LOAD, RF_RegSel = onehot(Rx).
  - 3 ST: RF_OutBSel = Rx, MuxCSel = 1, ALU_FunSel = ALU_PASSB, ARF_OutCSel = 10, Mem_CS = 0, Mem_WR = 1.
  - 4 MOV: RF_OutBSel = Rs, MuxCSel = 1, ALU_FunSel = ALU_PASSB, ALU_WF = 1, MuxASel = 00, RF_FunSel = FUN_LOAD, RF_RegSel = onehot(Rx).
  - 5 INC / 6 DEC: RF_FunSel = FUN_INC or FUN_DEC, RF_RegSel = onehot(Rx). Flags untouched.
  - 7 LDAR: MuxBSel = 10, ARF_FunSel = FUN_LOAD, ARF_RegSel = 3'b010.
  - 8 BRA: MuxBSel = 10, ARF_FunSel = FUN_LOAD, ARF_RegSel = 3'b100.
  - 9 BZ: behaves as BRA when ALUFlags[3] = 1, otherwise as NOP.
  - F HLT: idle outputs, then HALT.
  - A-E: idle outputs plus Illegal = 1, treated as NOP.
- HALT: idle outputs with Halted = 1. Only Reset exits.
- Latency: 3 cycles per instruction at Run = 1. The PC is already incremented by 2 when EXEC executes.
- Reset mid-fetch or mid-EXEC: outputs go idle immediately and the in-progress write is abandoned. INIT then re-clears all registers.

Test Plan:
- Reset low, release with Run = 0 -> INIT: ARF_RegSel = 111, RF_RegSel = 1111, FunSel = 011; then FETCH_L holding with Mem_CS = 1 indefinitely.
- Run = 1, IROut = 16'h1_5_A5 (LDI R2) in EXEC -> cycle sequence:
  - IR_LH 0 then 1, IR_Write = 1.
  - PC INC twice.
  - EXEC: MuxASel = 10, RF_RegSel = 0100, RF_FunSel = 010.
- IROut = 16'h4_D_00 (MOV R4, R2) -> RF_OutBSel = 001, MuxCSel = 1, ALU_FunSel = 10001, ALU_WF = 1, RF_RegSel = 0001.
- BZ 16'h9_0_3C:
  - With ALUFlags = 4'b1000 -> ARF_RegSel = 100, MuxBSel = 10.
  - With ALUFlags = 4'b0000 -> all idle.
- IROut = 16'hB000 -> Illegal pulses exactly one cycle, next state FETCH_L. IROut = 16'hF000 -> Halted = 1 held across 10 cycles with Run toggling.
- Assert Reset during FETCH_H -> IR_Write and Mem_CS deassert the same cycle, before the clock edge; after release, the INIT clear recurs.
